// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule FSM states, round constants and the
// forward S-box table used by both the key expander and SubBytes.
package aes_pkg;

    localparam int NK        = 4;
    localparam int NUM_WORDS = 44;

    typedef enum logic [1:0] {
        KEXP_IDLE   = 2'd0,
        KEXP_LOAD   = 2'd1,
        KEXP_EXPAND = 2'd2,
        KEXP_DONE   = 2'd3
    } kexp_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round indices outside 1..10 never occur in a valid schedule; return 0 rather than X.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load and round-key read bus between the state manager and the key expander.
interface aes_key_expander_if;
    logic        key_start;
    logic        key_col_valid;
    logic [1:0]  key_col_idx;
    logic [31:0] key_col_in;
    logic        key_expand_done;
    logic [3:0]  rk_round;
    logic [1:0]  rk_col;
    logic [31:0] rk_word;

    modport master (
        output key_start, key_col_valid, key_col_idx, key_col_in, rk_round, rk_col,
        input  key_expand_done, rk_word
    );

    modport slave (
        input  key_start, key_col_valid, key_col_idx, key_col_in, rk_round, rk_col,
        output key_expand_done, rk_word
    );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: combinational byte substitution from the shared table.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = SBOX[din];
endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: loads four key columns, expands one word per cycle into
// 44-word storage and serves round keys through a combinational read mux.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    aes_key_expander_if.slave   kif,
    output logic [1:0]          dbg_state
);
    if (NR != 10) begin : g_nr_check
        $error("aes_key_expander supports only NR = 10 (AES-128)");
    end

    kexp_state_t state, state_nxt;
    logic [3:0]  mask, mask_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        done, done_nxt;
    logic [31:0] w [NUM_WORDS];

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] prev_w, rot_w, sub_w, temp_w;
    logic [3:0]  col_bit;

    assign col_bit = 4'b0001 << kif.key_col_idx;
    assign prev_w  = w[cnt - 6'd1];
    assign rot_w   = {prev_w[23:0], prev_w[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (.din(rot_w[8*b +: 8]), .dout(sub_w[8*b +: 8]));
    end

    assign temp_w = (cnt[1:0] == 2'b00) ? (sub_w ^ {rcon_byte(cnt[5:2]), 24'h0}) : prev_w;

    // key_start overrides every state, including an in-flight expansion.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        cnt_nxt   = cnt;
        done_nxt  = done;
        wr_en     = 1'b0;
        wr_addr   = cnt;
        wr_data   = w[cnt - 6'd4] ^ temp_w;
        if (kif.key_start) begin
            state_nxt = KEXP_LOAD;
            done_nxt  = 1'b0;
            cnt_nxt   = 6'd4;
            mask_nxt  = kif.key_col_valid ? col_bit : 4'b0000;
            if (kif.key_col_valid) begin
                wr_en   = 1'b1;
                wr_addr = {4'd0, kif.key_col_idx};
                wr_data = kif.key_col_in;
            end
        end else begin
            case (state)
                KEXP_LOAD: begin
                    if (kif.key_col_valid) begin
                        wr_en    = 1'b1;
                        wr_addr  = {4'd0, kif.key_col_idx};
                        wr_data  = kif.key_col_in;
                        mask_nxt = mask | col_bit;
                        if (mask_nxt == 4'b1111) begin
                            state_nxt = KEXP_EXPAND;
                            cnt_nxt   = 6'd4;
                        end
                    end
                end
                KEXP_EXPAND: begin
                    wr_en = 1'b1;
                    if (cnt == 6'(NUM_WORDS - 1)) begin
                        state_nxt = KEXP_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= KEXP_IDLE;
            mask  <= 4'b0000;
            cnt   <= 6'd4;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // Word storage carries no reset; the read mux hides it until done.
    always_ff @(posedge clock) begin
        if (wr_en) w[wr_addr] <= wr_data;
    end

    assign kif.key_expand_done = done;
    assign kif.rk_word = (done && kif.rk_round <= 4'd10) ? w[{kif.rk_round, kif.rk_col}] : 32'h0;
    assign dbg_state   = state;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed-vector bench for aes_key_expander using FIPS-197 and all-zero key schedules.
module tb_aes_key_expander;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    aes_key_expander_if kif();

    aes_key_expander #(.NR(10)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .kif       (kif),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int edges   = 0;
    int last_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic put_col(input logic s, input logic [1:0] idx, input logic [31:0] d);
        kif.key_start     = s;
        kif.key_col_valid = 1'b1;
        kif.key_col_idx   = idx;
        kif.key_col_in    = d;
        step();
        kif.key_start     = 1'b0;
        kif.key_col_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] key);
        for (int c = 0; c < 4; c++)
            put_col(c == 0, 2'(c), key[127 - 32*c -: 32]);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!kif.key_expand_done && n < max) begin
            step();
            n++;
        end
        if (!kif.key_expand_done) chk("done_timeout", 32'(kif.key_expand_done), 32'd1);
    endtask

    task automatic rd(input string tag, input int r, input int c, input logic [31:0] exp);
        kif.rk_round = 4'(r);
        kif.rk_col   = 2'(c);
        #1;
        chk(tag, kif.rk_word, exp);
    endtask

    initial begin
        kif.key_start     = 1'b0;
        kif.key_col_valid = 1'b0;
        kif.key_col_idx   = 2'd0;
        kif.key_col_in    = 32'h0;
        kif.rk_round      = 4'd0;
        kif.rk_col        = 2'd0;

        #1;
        chk("rst_done", 32'(kif.key_expand_done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rd("rst_rk", 0, 0, 32'h0);
        #10;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("idle_state", 32'(dbg_state), 32'd0);

        // FIPS-197 key, in-order columns from the key_start cycle
        edges = 0;
        load_key(FIPS_KEY);
        chk("fips_expand_state", 32'(dbg_state), 32'd2);
        wait_done(60);
        chk("fips_latency", 32'(edges), 32'd44);
        chk("fips_done_state", 32'(dbg_state), 32'd3);
        rd("fips_r1c0", 1, 0, 32'ha0fafe17);
        rd("fips_r1c1", 1, 1, 32'h88542cb1);
        rd("fips_r1c2", 1, 2, 32'h23a33939);
        rd("fips_r1c3", 1, 3, 32'h2a6c7605);
        rd("fips_r2c0", 2, 0, 32'hf2c295f2);
        rd("fips_r10c0", 10, 0, 32'hd014f9a8);
        rd("fips_r10c1", 10, 1, 32'hc9ee2589);
        rd("fips_r10c2", 10, 2, 32'he13f0cc8);
        rd("fips_r10c3", 10, 3, 32'hb6630ca6);
        rd("fips_r0c3", 0, 3, 32'h09cf4f3c);
        rd("rk_round11", 11, 0, 32'h0);
        rd("rk_round15", 15, 3, 32'h0);
        repeat (100) step();
        chk("done_hold", 32'(kif.key_expand_done), 32'd1);
        rd("hold_r10c3", 10, 3, 32'hb6630ca6);

        // key_col_valid without key_start in DONE must be ignored
        kif.key_col_valid = 1'b1;
        kif.key_col_idx   = 2'd0;
        kif.key_col_in    = 32'hffffffff;
        step();
        kif.key_col_valid = 1'b0;
        chk("ignore_state", 32'(dbg_state), 32'd3);
        rd("ignore_r0c0", 0, 0, 32'h2b7e1516);

        // All-zero key
        load_key(ZERO_KEY);
        wait_done(60);
        rd("zero_w4", 1, 0, 32'h62636363);
        rd("zero_r1c3", 1, 3, 32'h62636363);
        rd("zero_r10c0", 10, 0, 32'hb4ef5bcb);
        rd("zero_r10c1", 10, 1, 32'h3e92e211);
        rd("zero_r10c2", 10, 2, 32'h23e951cf);
        rd("zero_r10c3", 10, 3, 32'h6f8f188e);

        // Out-of-order columns with idle gaps and a duplicate index
        put_col(1'b1, 2'd2, 32'hdeadbeef);
        chk("ooo_start_done", 32'(kif.key_expand_done), 32'd0);
        repeat (3) step();
        put_col(1'b0, 2'd0, FIPS_KEY[127:96]);
        repeat (2) step();
        put_col(1'b0, 2'd2, FIPS_KEY[63:32]);
        step();
        put_col(1'b0, 2'd3, FIPS_KEY[31:0]);
        repeat (4) step();
        chk("ooo_still_load", 32'(dbg_state), 32'd1);
        put_col(1'b0, 2'd1, FIPS_KEY[95:64]);
        last_edge = edges;
        chk("ooo_expand", 32'(dbg_state), 32'd2);
        wait_done(60);
        chk("ooo_latency", 32'(edges - last_edge), 32'd40);
        rd("ooo_r0c2", 0, 2, 32'habf71588);
        rd("ooo_r10c0", 10, 0, 32'hd014f9a8);
        rd("ooo_r10c3", 10, 3, 32'hb6630ca6);

        // Restart with the zero key at cycle 20 of a FIPS expansion
        put_col(1'b1, 2'd0, FIPS_KEY[127:96]);
        chk("restart_drop", 32'(kif.key_expand_done), 32'd0);
        chk("restart_load", 32'(dbg_state), 32'd1);
        for (int c = 1; c < 4; c++) put_col(1'b0, 2'(c), FIPS_KEY[127 - 32*c -: 32]);
        repeat (19) step();
        chk("abort_mid_expand", 32'(dbg_state), 32'd2);
        put_col(1'b1, 2'd0, 32'h0);
        chk("abort_state", 32'(dbg_state), 32'd1);
        chk("abort_done", 32'(kif.key_expand_done), 32'd0);
        for (int c = 1; c < 4; c++) put_col(1'b0, 2'(c), 32'h0);
        wait_done(60);
        rd("abort_r1c0", 1, 0, 32'h62636363);
        rd("abort_r10c0", 10, 0, 32'hb4ef5bcb);
        rd("abort_r10c3", 10, 3, 32'h6f8f188e);

        // Asynchronous reset mid-expansion
        load_key(FIPS_KEY);
        repeat (10) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_done", 32'(kif.key_expand_done), 32'd0);
        chk("arst_state", 32'(dbg_state), 32'd0);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 4; c++)
                rd($sformatf("arst_rk_r%0dc%0d", r, c), r, c, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("post_rst_state", 32'(dbg_state), 32'd0);
        load_key(FIPS_KEY);
        wait_done(60);
        rd("post_rst_r10c3", 10, 3, 32'hb6630ca6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
